c5efa7_fpga_bup_qsys_irq_ctrl: RTL and testbench
================================================

Name: c5efa7_fpga_bup_qsys_irq_ctrl

Overview:
Interrupt aggregator that sits directly downstream of the system clock timer and other peripheral irq lines. It combines them into a single CPU irq.
- Each source is captured as edge or level, then masked.
- The lowest-index pending, enabled source is reported as a vector.
- An optional holdoff counter rate-limits irq re-assertion (coalescing).
- Control and status go through a 16-bit Avalon-MM slave with the same access style as the timer.

Parameters:
N_SRC, 8, number of irq sources (1..15)
EDGE_RST, 8'hFF, reset value of EDGE_SEL (1 = rising-edge capture, 0 = level)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, synchronous, active-low (asserted when 0, sampled on rising clk)
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq_in  in  N_SRC  source irq lines; bit 0 is the sys clk timer irq
irq  out  1  aggregated CPU interrupt

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge):
  - PENDING=0, MASK=0, EDGE_SEL=EDGE_RST, HOLDOFF=0, irq_q=0.
  - State=IDLE, hold_cnt=0, readdata=0, irq=0.
  - Reset mid-holdoff aborts to IDLE.
- Register map (write = chipselect & ~write_n). Bits above N_SRC-1 read 0.
  - 0 PENDING: read pending bits. Write 1 clears edge-mode bits; write is ignored for level-mode bits.
  - 1 MASK: rw enable bits.
  - 2 EDGE_SEL: rw.
  - 3 VECTOR: ro. {bit15=valid, bits3:0=lowest index i with PENDING[i]&MASK[i]}; reads 0 when none.
  - 4 HOLDOFF: rw 16-bit cycle count.
  - 5 RAW: ro, irq_q.
  - 6,7: read 0, writes ignored.
- Read: readdata registered every cycle from address (chipselect not required). Valid 1 cycle after address is presented.
- Capture:
  - irq_q <= irq_in every cycle.
  - Edge mode: PENDING[i] set at the edge where irq_in[i]=1 and irq_q[i]=0.
  - Level mode: PENDING[i] <= irq_in[i] every cycle.
  - Simultaneous set and write-1-clear on the same bit: set wins.
  - Switching EDGE_SEL from level to edge leaves the current PENDING value; software clears it.
- active = |(PENDING & MASK), combinational from registers.
- FSM (irq = state==ASSERTED):
  - IDLE: active=1 -> ASSERTED.
  - ASSERTED: active=0 and HOLDOFF==0 -> IDLE. active=0 and HOLDOFF!=0 -> HOLDOFF, loading hold_cnt=HOLDOFF-1.
  - HOLDOFF: irq=0. hold_cnt decrements each cycle. hold_cnt==0 -> IDLE (exactly HOLDOFF cycles in state). New events still set PENDING here but do not raise irq until IDLE.
  - Writing HOLDOFF during HOLDOFF state does not affect the running count.
- Latency: source rising edge sampled at edge k -> PENDING at k -> irq high after edge k+1 (2 cycles from irq_in high to irq high).
  - Clear write at edge k -> irq low after edge k+1.
- Masking an active source in ASSERTED drops irq via the active=0 path (holdoff applies).
- hold_cnt width 16; no wrap. HOLDOFF=1 gives 1 holdoff cycle.

Decomposition:
- Package c5efa7_fpga_bup_irq_pkg holds:
  - register address constants (ADDR_PENDING..ADDR_RAW);
  - FSM state encoding (IDLE=2'd0, ASSERTED=2'd1, HOLDOFF=2'd2);
  - VECTOR valid bit position 15.
- One sub-module, c5efa7_fpga_bup_irq_prio_enc: combinational lowest-index priority encoder for N_SRC bits, outputting {valid, index[3:0]}.

Test Plan:
- Reset: hold reset_n=0 for 2 clks with irq_in=8'hFF -> irq=0, readdata=0; reads return PENDING=0, MASK=0, EDGE_SEL=8'hFF.
- Edge capture and vector:
  - MASK=8'h01, pulse irq_in[0] for 1 cycle -> irq high 2 cycles after pulse start; VECTOR read=16'h8000.
  - Write PENDING=16'h0001 -> irq low the cycle after the write edge.
- Priority: MASK=8'h0C, pulse irq_in[3] then irq_in[2] -> VECTOR=16'h8002. Clear bit 2 -> VECTOR=16'h8003, irq stays high.
- Level mode: EDGE_SEL=0, MASK=8'h10, hold irq_in[4]=1 -> irq stays high despite writes of PENDING=16'h0010. Drop irq_in[4] -> irq low 2 cycles later.
- Holdoff: HOLDOFF=5, assert and clear source 0, then pulse source 0 immediately -> irq stays low exactly 5 cycles after the clear takes effect, then re-asserts. Same clear-then-pulse with HOLDOFF=0 -> re-asserts without gap.
- Collision and reset mid-holdoff:
  - Write-1-clear on bit 1 in the same cycle as a new edge on irq_in[1] -> PENDING[1]=1.
  - reset_n=0 during HOLDOFF (cnt=3) -> next cycle state IDLE, irq=0, HOLDOFF=0.

Source files
------------

// File: rtl/c5efa7_fpga_bup_irq_pkg.sv
// Shared constants for the interrupt aggregator: register map, FSM states,
// and the VECTOR register layout.
package c5efa7_fpga_bup_irq_pkg;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_VECTOR   = 3'd3;
    localparam logic [2:0] ADDR_HOLDOFF  = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;

    localparam int unsigned VEC_VALID_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERTED = 2'd1,
        ST_HOLDOFF  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/c5efa7_fpga_bup_irq_prio_enc.sv
// Lowest-index priority encoder: reports the smallest set bit of req_i.
module c5efa7_fpga_bup_irq_prio_enc #(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             valid_o,
    output logic [3:0]       index_o
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (req_i[i-1]) begin
                valid_o = 1'b1;
                index_o = 4'(i - 1);
            end
        end
    end

endmodule

// File: rtl/c5efa7_fpga_bup_qsys_irq_ctrl.sv
// Interrupt aggregator: per-source edge/level capture, masking, lowest-index
// vector, holdoff coalescing, and a 16-bit Avalon-MM register slave.
module c5efa7_fpga_bup_qsys_irq_ctrl
    import c5efa7_fpga_bup_irq_pkg::*;
#(
    parameter int unsigned       N_SRC    = 8,
    parameter logic [N_SRC-1:0]  EDGE_RST = 8'hFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    input  logic [N_SRC-1:0] irq_in,
    output logic             irq
);

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [15:0]      holdoff_q, holdoff_d;
    logic [15:0]      readdata_q, readdata_d;
    logic [15:0]      hold_cnt_q;
    logic             irq_out_q;
    irq_state_e       state_q;

    logic             wr_en;
    logic [N_SRC-1:0] clr_bits;
    logic [N_SRC-1:0] rise;
    logic             active;
    logic             vec_valid;
    logic [3:0]       vec_index;

    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && address == ADDR_PENDING) ? writedata[N_SRC-1:0] : '0;
    assign rise     = irq_in & ~irq_q;
    assign active   = |(pending_q & mask_q);

    c5efa7_fpga_bup_irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req_i   (pending_q & mask_q),
        .valid_o (vec_valid),
        .index_o (vec_index)
    );

    // Edge bits: a new rising edge beats a same-cycle write-1-clear.
    always_comb begin
        pending_d  = (edge_sel_q & (rise | (pending_q & ~clr_bits)))
                   | (~edge_sel_q & irq_in);
        mask_d     = (wr_en && address == ADDR_MASK)     ? writedata[N_SRC-1:0] : mask_q;
        edge_sel_d = (wr_en && address == ADDR_EDGE_SEL) ? writedata[N_SRC-1:0] : edge_sel_q;
        holdoff_d  = (wr_en && address == ADDR_HOLDOFF)  ? writedata : holdoff_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_PENDING:  readdata_d = 16'(pending_q);
            ADDR_MASK:     readdata_d = 16'(mask_q);
            ADDR_EDGE_SEL: readdata_d = 16'(edge_sel_q);
            ADDR_VECTOR: begin
                readdata_d[VEC_VALID_BIT] = vec_valid;
                readdata_d[3:0]           = vec_index;
            end
            ADDR_HOLDOFF:  readdata_d = holdoff_q;
            ADDR_RAW:      readdata_d = 16'(irq_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= EDGE_RST;
            holdoff_q  <= '0;
            readdata_q <= '0;
        end else begin
            irq_q      <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            holdoff_q  <= holdoff_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (active) begin
                        state_q   <= ST_ASSERTED;
                        irq_out_q <= 1'b1;
                    end
                end
                ST_ASSERTED: begin
                    if (!active) begin
                        irq_out_q <= 1'b0;
                        if (holdoff_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q    <= ST_HOLDOFF;
                            hold_cnt_q <= holdoff_q - 16'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_out_q;

endmodule

// File: tb/tb_c5efa7_fpga_bup_qsys_irq_ctrl.sv
// Bench for the interrupt aggregator: directed scenarios plus a random phase,
// every cycle compared against a cycle-level behavioural model.
module tb_c5efa7_fpga_bup_qsys_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [15:0] wdata;
    logic [15:0] readdata;
    logic [7:0]  irq_in_v;
    logic        irq;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural model state
    logic [7:0]  m_pend, m_mask, m_edge, m_prev;
    int          m_hold;
    logic        m_irq;
    int          m_block;
    logic [15:0] m_rd;

    c5efa7_fpga_bup_qsys_irq_ctrl #(
        .N_SRC    (8),
        .EDGE_RST (8'hFF)
    ) dut (
        .clk        (clk),
        .reset_n    (rst_n),
        .address    (addr),
        .chipselect (cs),
        .write_n    (wr_n),
        .writedata  (wdata),
        .readdata   (readdata),
        .irq_in     (irq_in_v),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs present before it.
    task automatic model_step();
        logic [7:0] clr;
        logic [7:0] nxt;
        logic       act;
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_edge = 8'hFF; m_prev = '0;
            m_hold = 0;  m_irq = 1'b0; m_block = 0;  m_rd = '0;
            return;
        end
        act = (m_pend & m_mask) != 8'h00;
        case (addr)
            3'd0: m_rd = {8'h00, m_pend};
            3'd1: m_rd = {8'h00, m_mask};
            3'd2: m_rd = {8'h00, m_edge};
            3'd3: begin
                m_rd = '0;
                for (int i = 7; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) m_rd = 16'h8000 | 16'(i);
            end
            3'd4: m_rd = 16'(m_hold);
            3'd5: m_rd = {8'h00, m_prev};
            default: m_rd = '0;
        endcase
        if (m_block > 0) begin
            m_block--;
        end else if (m_irq) begin
            if (!act) begin
                m_irq   = 1'b0;
                m_block = m_hold;
            end
        end else if (act) begin
            m_irq = 1'b1;
        end
        clr = (cs && !wr_n && addr == 3'd0) ? wdata[7:0] : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) nxt[i] = (irq_in_v[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
            else           nxt[i] = irq_in_v[i];
        end
        m_pend = nxt;
        if (cs && !wr_n) begin
            case (addr)
                3'd1: m_mask = wdata[7:0];
                3'd2: m_edge = wdata[7:0];
                3'd4: m_hold = int'(wdata);
                default: ;
            endcase
        end
        m_prev = irq_in_v;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("irq_model", {15'd0, irq}, {15'd0, m_irq});
        chk("rdata_model", readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cs = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
        step();
        cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        addr = a;
        step();
        v = readdata;
    endtask

    // Clears source 0 while asserted, pulses it again, and counts irq-low cycles.
    task automatic clear_then_pulse(output int lows);
        wr(3'd0, 16'h0001);
        irq_in_v[0] = 1'b1;
        step();
        irq_in_v[0] = 1'b0;
        lows = (irq == 1'b0) ? 1 : 0;
        while (irq == 1'b0 && lows < 50) begin
            step();
            if (irq == 1'b0) lows++;
        end
        chk("reassert_timeout", {15'd0, lows < 50}, 16'd1);
    endtask

    initial begin
        logic [15:0] v;
        int          n5, n0;

        rst_n = 1'b0; cs = 1'b0; wr_n = 1'b1; addr = '0; wdata = '0; irq_in_v = 8'hFF;
        step();
        step();
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_rdata", readdata, 16'h0000);
        rst_n = 1'b1; irq_in_v = 8'h00;
        rd(3'd0, v); chk("rst_pending", v, 16'h0000);
        rd(3'd1, v); chk("rst_mask", v, 16'h0000);
        rd(3'd2, v); chk("rst_edge_sel", v, 16'h00FF);

        // Edge capture and vector
        wr(3'd1, 16'h0001);
        irq_in_v[0] = 1'b1;
        step();
        chk("edge_lat1", {15'd0, irq}, 16'd0);
        irq_in_v[0] = 1'b0;
        step();
        chk("edge_lat2", {15'd0, irq}, 16'd1);
        rd(3'd3, v); chk("vector_src0", v, 16'h8000);
        wr(3'd0, 16'h0001);
        chk("clr_still_high", {15'd0, irq}, 16'd1);
        step();
        chk("clr_irq_low", {15'd0, irq}, 16'd0);

        // Priority
        wr(3'd1, 16'h000C);
        irq_in_v = 8'h08; step();
        irq_in_v = 8'h04; step();
        irq_in_v = 8'h00;
        rd(3'd3, v); chk("vector_prio2", v, 16'h8002);
        wr(3'd0, 16'h0004);
        rd(3'd3, v); chk("vector_prio3", v, 16'h8003);
        chk("prio_irq_high", {15'd0, irq}, 16'd1);
        wr(3'd0, 16'h0008);
        step();

        // Level mode
        wr(3'd1, 16'h0010);
        wr(3'd2, 16'h0000);
        irq_in_v[4] = 1'b1;
        step(); step();
        chk("level_irq", {15'd0, irq}, 16'd1);
        wr(3'd0, 16'h0010);
        step();
        chk("level_clr_ignored", {15'd0, irq}, 16'd1);
        irq_in_v[4] = 1'b0;
        step();
        chk("level_drop1", {15'd0, irq}, 16'd1);
        step();
        chk("level_drop2", {15'd0, irq}, 16'd0);
        wr(3'd2, 16'h00FF);

        // Holdoff gap: HOLDOFF=5 against HOLDOFF=0
        wr(3'd1, 16'h0001);
        wr(3'd4, 16'h0005);
        irq_in_v[0] = 1'b1; step(); irq_in_v[0] = 1'b0; step();
        chk("ho_pre_irq", {15'd0, irq}, 16'd1);
        clear_then_pulse(n5);
        wr(3'd4, 16'h0000);
        clear_then_pulse(n0);
        chk("holdoff_gap", 16'(n5 - n0), 16'd5);
        wr(3'd0, 16'h0001);
        step(); step();

        // Collision: set beats write-1-clear
        wr(3'd1, 16'h0000);
        irq_in_v[1] = 1'b1;
        wr(3'd0, 16'h0002);
        irq_in_v[1] = 1'b0;
        rd(3'd0, v); chk("collision_set_wins", v & 16'h0002, 16'h0002);
        wr(3'd0, 16'h0002);

        // Reset mid-holdoff
        wr(3'd1, 16'h0001);
        wr(3'd4, 16'h0005);
        irq_in_v[0] = 1'b1; step(); irq_in_v[0] = 1'b0; step();
        wr(3'd0, 16'h0001);
        step(); step();
        chk("pre_rst_holdoff_low", {15'd0, irq}, 16'd0);
        rst_n = 1'b0;
        step();
        chk("midho_rst_irq", {15'd0, irq}, 16'd0);
        rst_n = 1'b1;
        rd(3'd4, v); chk("midho_rst_holdoff", v, 16'h0000);

        // Random phase
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            cs       = $urandom_range(0, 1) == 1;
            wr_n     = $urandom_range(0, 2) != 0;
            addr     = 3'($urandom_range(0, 7));
            wdata    = (addr == 3'd4) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            irq_in_v = irq_in_v ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
